segre_hazard_unit: RTL and testbench
====================================

// Module: segre_hazard_unit
// PURPOSE
//  Central pipeline hazard/stall controller for the 5-stage segre core (IF,ID,EX,MEM,WB).
//  Detects RAW hazards for NUM_SRC operands, i-cache misses, d-cache busy and taken branches.
//  Drives per-stage block/bubble controls, optional operand-forwarding selects and a saturating stall counter.
//  A small FSM sequences multi-cycle branch flushes and i-cache miss recovery.
// PARAMETERS
//  NUM_REGS     32  architectural registers; REG_W = $clog2(NUM_REGS); register 0 is never a hazard
//  NUM_SRC      2   source operands checked per ID instruction
//  FLUSH_DEPTH  1   cycles of bubbles injected into ID and EX after a taken branch (1..7)
//  CNT_W        16  width of stall_cnt_o
// PORTS
//  clk_i              in   1              clock, rising edge
//  rst_i              in   1              synchronous reset, active-high
//  ic_hit_i           in   1              IF fetch hit this cycle
//  dc_busy_i          in   1              MEM stage waiting on d-cache
//  branch_taken_ex_i  in   1              taken branch/jump resolved in EX
//  src_id_i           in   NUM_SRC*REG_W  ID source register indices, packed, operand 0 in LSBs
//  src_used_id_i      in   NUM_SRC        operand n is actually read
//  dst_ex_i/_mem_i/_wb_i  in  REG_W       destination index per stage
//  we_ex_i/_mem_i/_wb_i   in  1           stage writes the register file
//  load_ex_i          in   1              EX instruction is a load
//  block_if_o         out  1              hold PC/IF register
//  block_id_o         out  1              hold IF/ID register
//  block_ex_o         out  1              hold ID/EX register
//  block_mem_o        out  1              hold EX/MEM register
//  inject_nops_if_o   out  1              load bubble into IF/ID
//  inject_nops_id_o   out  1              load bubble into ID/EX
//  fwd_sel_o          out  NUM_SRC*2      per operand: 0 RF, 1 EX, 2 MEM, 3 WB
//  stall_cnt_o        out  CNT_W          saturating count of cycles with block_id_o=1
// BEHAVIOUR
//  - match(n,S) = src_used_id_i[n] && src_id_i[n]!=0 && we_S && src_id_i[n]==dst_S. Purely combinational.
//  - haz = any match(n,EX|MEM|WB) (no fwd), or any match(n,EX)&&load_ex_i (fwd); see CONFIGURATION.
//  - FSM states RUN, FLUSH, ICMISS; reset -> RUN, flush_cnt=0, stall_cnt_o=0.
//  - Per-cycle priority in RUN, highest first:
//    1 dc_busy_i: all block_*=1, all inject=0. FSM and flush_cnt are frozen.
//    2 branch_taken_ex_i: inject_nops_if_o=1, inject_nops_id_o=1, no blocks; the branch overrides haz and miss.
//      If FLUSH_DEPTH>1: go to FLUSH with flush_cnt=FLUSH_DEPTH-1.
//    3 haz: block_if_o=block_id_o=1, inject_nops_id_o=1.
//    4 !ic_hit_i: block_if_o=1, inject_nops_if_o=1, go to ICMISS.
//  - FLUSH: inject_nops_if_o=inject_nops_id_o=1 and flush_cnt decrements. Return to RUN after the cycle with flush_cnt==1.
//    dc_busy_i still wins; a new branch_taken reloads flush_cnt.
//  - ICMISS: block_if_o=1 and inject_nops_if_o=1 while !ic_hit_i. The first hit cycle behaves like RUN and returns to RUN.
//    A branch_taken while in ICMISS flushes and goes to FLUSH or RUN; the miss is re-detected on the redirected fetch.
//  - Outputs are combinational from state and inputs. Reset forces every block/inject output to 0 and fwd_sel_o to 0.
//  - stall_cnt_o increments on every cycle with block_id_o=1 and saturates at all-ones.
//  - rst_i mid-flush or mid-miss: the next cycle is RUN and the counter is cleared.
// CONFIGURATION
//  SEGRE_FWD_EN defined: fwd_sel_o picks the youngest match (EX > MEM > WB); only load-use in EX stalls.
//  SEGRE_FWD_EN undefined: fwd_sel_o is tied to 0 and any EX/MEM/WB match stalls.
// STRUCTURE
//  segre_pkg: hz_state_e {RUN,FLUSH,ICMISS}, fwd_sel_e {FWD_RF,FWD_EX,FWD_MEM,FWD_WB}, REG_W.
//  One sub-module, segre_hazard_cmp: per-operand match/priority encoder, instantiated NUM_SRC times.
// TESTING
//  - src0=5 used, dst_ex=5, we_ex=1, no fwd -> block_if/id=1, inject_id=1, stall_cnt 0->1.
//  - SEGRE_FWD_EN, src0=5 vs dst_mem=5 and dst_wb=5 -> fwd_sel[0]=2, no stall. load_ex=1 with dst_ex=5 -> 1-cycle stall.
//  - src0=0 vs dst_ex=0, we_ex=1 -> no stall, fwd_sel=0.
//  - FLUSH_DEPTH=3, branch_taken pulse -> inject_if/id=1 for 3 cycles; dc_busy in cycle 2 -> all blocks, flush extended 1 cycle.
//  - ic_hit=0 for 4 cycles, then hit -> block_if/inject_if=1 for 4 cycles, back to RUN. Same with branch in cycle 2 -> flush wins.
//  - Hazard + !ic_hit together -> hazard controls apply, FSM stays RUN. rst_i=1 in FLUSH -> outputs 0, stall_cnt=0.
//  - Force 2^CNT_W stall cycles -> stall_cnt_o holds 0xFFFF.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre pipeline hazard controller.
// Holds the FSM state encoding, the operand-forwarding select encoding and
// the default geometry used by the hazard unit and its interface.
package segre_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int REG_W        = $clog2(DEF_NUM_REGS);
  localparam int DEF_NUM_SRC  = 2;
  localparam int DEF_CNT_W    = 16;
  // Wide enough for FLUSH_DEPTH up to 7.
  localparam int FLUSH_W      = 3;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    ICMISS
  } hz_state_e;

  // Operand source select seen by the ID/EX operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Per-stage pipeline register controls produced every cycle.
  typedef struct packed {
    logic blk_if;
    logic blk_id;
    logic blk_ex;
    logic blk_mem;
    logic inj_if;
    logic inj_id;
  } hz_ctrl_t;

endpackage

// File: rtl/segre_hazard_unit_if.sv
// Bundle between the segre pipeline datapath and the hazard unit.
// master: the hazard unit (consumes stage status, drives controls).
// slave:  the pipeline (drives stage status, consumes controls).
interface segre_hazard_unit_if #(
  parameter int NUM_SRC = segre_pkg::DEF_NUM_SRC,
  parameter int REG_W   = segre_pkg::REG_W,
  parameter int CNT_W   = segre_pkg::DEF_CNT_W
);

  // Stage status towards the hazard unit.
  logic                       ic_hit_i;
  logic                       dc_busy_i;
  logic                       branch_taken_ex_i;
  logic [NUM_SRC*REG_W-1:0]   src_id_i;
  logic [NUM_SRC-1:0]         src_used_id_i;
  logic [REG_W-1:0]           dst_ex_i;
  logic [REG_W-1:0]           dst_mem_i;
  logic [REG_W-1:0]           dst_wb_i;
  logic                       we_ex_i;
  logic                       we_mem_i;
  logic                       we_wb_i;
  logic                       load_ex_i;

  // Pipeline controls from the hazard unit.
  logic                       block_if_o;
  logic                       block_id_o;
  logic                       block_ex_o;
  logic                       block_mem_o;
  logic                       inject_nops_if_o;
  logic                       inject_nops_id_o;
  logic [NUM_SRC*2-1:0]       fwd_sel_o;
  logic [CNT_W-1:0]           stall_cnt_o;

  modport master (
    input  ic_hit_i, dc_busy_i, branch_taken_ex_i, src_id_i, src_used_id_i,
    input  dst_ex_i, dst_mem_i, dst_wb_i, we_ex_i, we_mem_i, we_wb_i, load_ex_i,
    output block_if_o, block_id_o, block_ex_o, block_mem_o,
    output inject_nops_if_o, inject_nops_id_o, fwd_sel_o, stall_cnt_o
  );

  modport slave (
    output ic_hit_i, dc_busy_i, branch_taken_ex_i, src_id_i, src_used_id_i,
    output dst_ex_i, dst_mem_i, dst_wb_i, we_ex_i, we_mem_i, we_wb_i, load_ex_i,
    input  block_if_o, block_id_o, block_ex_o, block_mem_o,
    input  inject_nops_if_o, inject_nops_id_o, fwd_sel_o, stall_cnt_o
  );

endinterface

// File: rtl/segre_hazard_cmp.sv
// Per-operand RAW comparator for one ID source register.
// Compares the operand against the EX, MEM and WB destinations and reports
// the youngest producing stage (FWD_RF when nothing in flight writes it).
// Register 0 is hardwired and never produces a dependency.
module segre_hazard_cmp
  import segre_pkg::*;
#(
  parameter int IDX_W = REG_W
) (
  input  logic [IDX_W-1:0] src,
  input  logic             used,
  input  logic [IDX_W-1:0] dst_ex,
  input  logic [IDX_W-1:0] dst_mem,
  input  logic [IDX_W-1:0] dst_wb,
  input  logic             we_ex,
  input  logic             we_mem,
  input  logic             we_wb,
  output fwd_sel_e         youngest
);

  logic live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign live    = used && (src != '0);
  assign hit_ex  = live && we_ex  && (src == dst_ex);
  assign hit_mem = live && we_mem && (src == dst_mem);
  assign hit_wb  = live && we_wb  && (src == dst_wb);

  // Priority-encode the youngest in-flight producer of this operand.
  always_comb begin
    // NOTE: default assignment first, so every path drives youngest and no latch is inferred.
    youngest = FWD_RF;
    if (hit_ex) begin
      youngest = FWD_EX;
    end else if (hit_mem) begin
      youngest = FWD_MEM;
    end else if (hit_wb) begin
      youngest = FWD_WB;
    end
  end

endmodule

// File: rtl/segre_hazard_unit.sv
// Central hazard/stall controller for the 5-stage segre core.
// Detects RAW hazards, i-cache misses, d-cache busy and taken branches and
// drives per-stage block/bubble controls plus a saturating stall counter.
// A RUN/FLUSH/ICMISS FSM sequences multi-cycle branch flushes and i-cache
// miss recovery; outputs are combinational from state and inputs.
// Build option: define SEGRE_FWD_EN to enable operand forwarding (fwd_sel_o
// follows the youngest producer and only a load-use in EX stalls); without
// it fwd_sel_o is 0 and any in-flight producer stalls ID.
module segre_hazard_unit
  import segre_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  segre_hazard_unit_if.master  hz
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_DEPTH - 1);

  hz_state_e          state_q;
  hz_state_e          state_d;
  logic [FLUSH_W-1:0] flush_q;
  logic [FLUSH_W-1:0] flush_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  hz_ctrl_t           ctrl;

  fwd_sel_e           youngest [NUM_SRC];
  logic [NUM_SRC-1:0] ex_match;
  logic               load_use;
  logic               haz;

  // One comparator per ID source operand.
  for (genvar n = 0; n < NUM_SRC; n++) begin : g_cmp
    segre_hazard_cmp #(
      .IDX_W (IDX_W)
    ) u_cmp (
      .src      (hz.src_id_i[n*IDX_W +: IDX_W]),
      .used     (hz.src_used_id_i[n]),
      .dst_ex   (hz.dst_ex_i),
      .dst_mem  (hz.dst_mem_i),
      .dst_wb   (hz.dst_wb_i),
      .we_ex    (hz.we_ex_i),
      .we_mem   (hz.we_mem_i),
      .we_wb    (hz.we_wb_i),
      .youngest (youngest[n])
    );
    assign ex_match[n] = (youngest[n] == FWD_EX);
  end

  // A load in EX cannot forward its result until MEM completes.
  assign load_use = (|ex_match) && hz.load_ex_i;

`ifdef SEGRE_FWD_EN
  assign haz = load_use;

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_fwd
    assign hz.fwd_sel_o[2*n +: 2] = rst_i ? 2'b00 : 2'(youngest[n]);
  end
`else
  logic [NUM_SRC-1:0] any_match;

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_any
    assign any_match[n] = (youngest[n] != FWD_RF);
  end

  // Without bypass paths every in-flight producer stalls; load-use is a subset.
  assign haz = load_use || (|any_match);
  assign hz.fwd_sel_o = '0;
`endif

  // Per-cycle priority decode: d-cache busy, branch, then state-specific work.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    flush_d = flush_q;

    if (hz.dc_busy_i) begin
      // Freeze the whole pipe; FSM and flush count hold.
      ctrl.blk_if  = 1'b1;
      ctrl.blk_id  = 1'b1;
      ctrl.blk_ex  = 1'b1;
      ctrl.blk_mem = 1'b1;
    end else if (hz.branch_taken_ex_i) begin
      // Squash the wrong-path IF and ID instructions from any state.
      ctrl.inj_if = 1'b1;
      ctrl.inj_id = 1'b1;
      if (FLUSH_DEPTH > 1) begin
        state_d = FLUSH;
        flush_d = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (haz) begin
            ctrl.blk_if = 1'b1;
            ctrl.blk_id = 1'b1;
            ctrl.inj_id = 1'b1;
          end else if (!hz.ic_hit_i) begin
            ctrl.blk_if = 1'b1;
            ctrl.inj_if = 1'b1;
            state_d     = ICMISS;
          end
        end
        FLUSH: begin
          ctrl.inj_if = 1'b1;
          ctrl.inj_id = 1'b1;
          flush_d     = flush_q - 1'b1;
          if (flush_q <= FLUSH_W'(1)) begin
            state_d = RUN;
          end
        end
        ICMISS: begin
          if (!hz.ic_hit_i) begin
            ctrl.blk_if = 1'b1;
            ctrl.inj_if = 1'b1;
          end else begin
            // Fetch returned: behave like RUN for this cycle.
            state_d = RUN;
            if (haz) begin
              ctrl.blk_if = 1'b1;
              ctrl.blk_id = 1'b1;
              ctrl.inj_id = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (rst_i) begin
      ctrl = '0;
    end
  end

  // FSM state, flush countdown and saturating stall counter.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q     <= RUN;
      flush_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (ctrl.blk_id && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign hz.block_if_o       = ctrl.blk_if;
  assign hz.block_id_o       = ctrl.blk_id;
  assign hz.block_ex_o       = ctrl.blk_ex;
  assign hz.block_mem_o      = ctrl.blk_mem;
  assign hz.inject_nops_if_o = ctrl.inj_if;
  assign hz.inject_nops_id_o = ctrl.inj_id;
  assign hz.stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_segre_hazard_unit.sv
// Self-checking bench for segre_hazard_unit.
// Two instances (FLUSH_DEPTH 3 and 1) see identical stimulus; a behavioural
// model tracks remaining flush cycles, a pending-miss flag and a stall count
// and predicts every control output once per cycle.
module tb_segre_hazard_unit;
  import segre_pkg::*;

  localparam int RW      = 5;
  localparam int NS      = 2;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  segre_hazard_unit_if #(.NUM_SRC(NS), .REG_W(RW), .CNT_W(CW)) bus3 ();
  segre_hazard_unit_if #(.NUM_SRC(NS), .REG_W(RW), .CNT_W(CW)) bus1 ();

  assign bus1.ic_hit_i          = bus3.ic_hit_i;
  assign bus1.dc_busy_i         = bus3.dc_busy_i;
  assign bus1.branch_taken_ex_i = bus3.branch_taken_ex_i;
  assign bus1.src_id_i          = bus3.src_id_i;
  assign bus1.src_used_id_i     = bus3.src_used_id_i;
  assign bus1.dst_ex_i          = bus3.dst_ex_i;
  assign bus1.dst_mem_i         = bus3.dst_mem_i;
  assign bus1.dst_wb_i          = bus3.dst_wb_i;
  assign bus1.we_ex_i           = bus3.we_ex_i;
  assign bus1.we_mem_i          = bus3.we_mem_i;
  assign bus1.we_wb_i           = bus3.we_wb_i;
  assign bus1.load_ex_i         = bus3.load_ex_i;

  segre_hazard_unit #(.NUM_REGS(32), .NUM_SRC(NS), .FLUSH_DEPTH(3), .CNT_W(CW)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (bus3.master)
  );

  segre_hazard_unit #(.NUM_REGS(32), .NUM_SRC(NS), .FLUSH_DEPTH(1), .CNT_W(CW)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (bus1.master)
  );

  // {block_if, block_id, block_ex, block_mem, inject_if, inject_id}
  logic [5:0] ctrl3, ctrl1;
  assign ctrl3 = {bus3.block_if_o, bus3.block_id_o, bus3.block_ex_o, bus3.block_mem_o,
                  bus3.inject_nops_if_o, bus3.inject_nops_id_o};
  assign ctrl1 = {bus1.block_if_o, bus1.block_id_o, bus1.block_ex_o, bus1.block_mem_o,
                  bus1.inject_nops_if_o, bus1.inject_nops_id_o};

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_BUSY  = 6'b111100;
  localparam logic [5:0] C_FLUSH = 6'b000011;
  localparam logic [5:0] C_HAZ   = 6'b110001;
  localparam logic [5:0] C_MISS  = 6'b100010;

  typedef struct {
    int flush_left;  // FLUSH cycles still owed after the branch cycle
    bit miss;        // waiting on an i-cache refill
    int cnt;         // expected stall_cnt_o
  } mdl_t;

  mdl_t m3, m1;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RAW hazard and forwarding prediction from the current ID/EX/MEM/WB view.
  function automatic logic model_haz(output logic [2*NS-1:0] fwd);
    int   dst [3];
    bit   we  [3];
    logic h;
    h      = 1'b0;
    fwd    = '0;
    dst[0] = int'(bus3.dst_ex_i);
    dst[1] = int'(bus3.dst_mem_i);
    dst[2] = int'(bus3.dst_wb_i);
    we[0]  = bus3.we_ex_i;
    we[1]  = bus3.we_mem_i;
    we[2]  = bus3.we_wb_i;
    for (int n = 0; n < NS; n++) begin
      int src;
      int young;
      src   = int'(bus3.src_id_i[n*RW +: RW]);
      young = 0;
      if (bus3.src_used_id_i[n] && src != 0) begin
        for (int s = 2; s >= 0; s--) begin
          if (we[s] && dst[s] == src) young = s + 1;
        end
      end
`ifdef SEGRE_FWD_EN
      fwd[2*n +: 2] = 2'(young);
      if (young == 1 && bus3.load_ex_i) h = 1'b1;
`else
      if (young != 0) h = 1'b1;
`endif
    end
    if (rst) fwd = '0;
    return h;
  endfunction

  function automatic void model_step(input int depth, input mdl_t s, input logic haz,
                                     output logic [5:0] exp, output mdl_t nx);
    nx = s;
    if (rst) begin
      exp           = C_NONE;
      nx.flush_left = 0;
      nx.miss       = 1'b0;
      nx.cnt        = 0;
      return;
    end
    if (bus3.dc_busy_i) begin
      exp = C_BUSY;
    end else if (bus3.branch_taken_ex_i) begin
      exp           = C_FLUSH;
      nx.flush_left = depth - 1;
      nx.miss       = 1'b0;
    end else if (s.flush_left > 0) begin
      exp           = C_FLUSH;
      nx.flush_left = s.flush_left - 1;
    end else if (s.miss && !bus3.ic_hit_i) begin
      exp = C_MISS;
    end else begin
      nx.miss = 1'b0;
      if (haz) begin
        exp = C_HAZ;
      end else if (!bus3.ic_hit_i) begin
        exp     = C_MISS;
        nx.miss = 1'b1;
      end else begin
        exp = C_NONE;
      end
    end
    if (exp[4] && s.cnt < CNT_MAX) nx.cnt = s.cnt + 1;
  endfunction

  // Compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic [5:0]      e3, e1;
    logic [2*NS-1:0] ef;
    logic            h;
    mdl_t            n3, n1;
    @(negedge clk);
    h = model_haz(ef);
    model_step(3, m3, h, e3, n3);
    model_step(1, m1, h, e1, n1);
    check("ctrl_d3", 32'(ctrl3), 32'(e3));
    check("ctrl_d1", 32'(ctrl1), 32'(e1));
    check("fwd_d3", 32'(bus3.fwd_sel_o), 32'(ef));
    check("fwd_d1", 32'(bus1.fwd_sel_o), 32'(ef));
    check("cnt_d3", 32'(bus3.stall_cnt_o), 32'(m3.cnt));
    check("cnt_d1", 32'(bus1.stall_cnt_o), 32'(m1.cnt));
    @(posedge clk);
    m3 = n3;
    m1 = n1;
    #1;
  endtask

  task automatic set_idle();
    rst                    = 1'b0;
    bus3.ic_hit_i          = 1'b1;
    bus3.dc_busy_i         = 1'b0;
    bus3.branch_taken_ex_i = 1'b0;
    bus3.src_id_i          = '0;
    bus3.src_used_id_i     = '0;
    bus3.dst_ex_i          = '0;
    bus3.dst_mem_i         = '0;
    bus3.dst_wb_i          = '0;
    bus3.we_ex_i           = 1'b0;
    bus3.we_mem_i          = 1'b0;
    bus3.we_wb_i           = 1'b0;
    bus3.load_ex_i         = 1'b0;
  endtask

  initial begin
    m3 = '{flush_left: 0, miss: 1'b0, cnt: 0};
    m1 = '{flush_left: 0, miss: 1'b0, cnt: 0};
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();                      // reset held: all controls 0, counter 0
    set_idle();
    cycle();

    // RAW on EX producer.
    bus3.src_id_i[RW-1:0] = 5'd5;
    bus3.src_used_id_i    = 2'b01;
    bus3.dst_ex_i         = 5'd5;
    bus3.we_ex_i          = 1'b1;
    cycle();
`ifdef SEGRE_FWD_EN
    check("cnt_after_haz", 32'(bus3.stall_cnt_o), 32'd0);
`else
    check("cnt_after_haz", 32'(bus3.stall_cnt_o), 32'd1);
`endif
    set_idle();
    cycle();

    // MEM and WB both produce r5; then load-use from EX.
    bus3.src_id_i[RW-1:0] = 5'd5;
    bus3.src_used_id_i    = 2'b01;
    bus3.dst_mem_i        = 5'd5;
    bus3.we_mem_i         = 1'b1;
    bus3.dst_wb_i         = 5'd5;
    bus3.we_wb_i          = 1'b1;
    cycle();
    bus3.dst_ex_i  = 5'd5;
    bus3.we_ex_i   = 1'b1;
    bus3.load_ex_i = 1'b1;
    cycle();
    set_idle();
    cycle();

    // Register 0 never creates a dependency.
    bus3.src_used_id_i = 2'b11;
    bus3.we_ex_i       = 1'b1;
    cycle();
    set_idle();

    // Branch pulse, then again with d-cache busy in the second cycle.
    bus3.branch_taken_ex_i = 1'b1;
    cycle();
    bus3.branch_taken_ex_i = 1'b0;
    repeat (4) cycle();
    bus3.branch_taken_ex_i = 1'b1;
    cycle();
    bus3.branch_taken_ex_i = 1'b0;
    bus3.dc_busy_i         = 1'b1;
    cycle();
    bus3.dc_busy_i = 1'b0;
    repeat (4) cycle();

    // Four-cycle miss, then the same with a branch in cycle 2.
    bus3.ic_hit_i = 1'b0;
    repeat (4) cycle();
    bus3.ic_hit_i = 1'b1;
    repeat (2) cycle();
    bus3.ic_hit_i = 1'b0;
    cycle();
    bus3.branch_taken_ex_i = 1'b1;
    cycle();
    bus3.branch_taken_ex_i = 1'b0;
    repeat (2) cycle();
    bus3.ic_hit_i = 1'b1;
    repeat (3) cycle();

    // Hazard together with a miss: hazard wins, no miss entry.
    bus3.ic_hit_i         = 1'b0;
    bus3.src_id_i[RW-1:0] = 5'd7;
    bus3.src_used_id_i    = 2'b01;
    bus3.dst_ex_i         = 5'd7;
    bus3.we_ex_i          = 1'b1;
    bus3.load_ex_i        = 1'b1;
    cycle();
    set_idle();
    cycle();

    // Reset in the middle of a flush.
    bus3.branch_taken_ex_i = 1'b1;
    cycle();
    set_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Randomised traffic over a small register window to provoke matches.
    for (int i = 0; i < 1500; i++) begin
      rst                    = ($urandom_range(0, 199) == 0);
      bus3.dc_busy_i         = ($urandom_range(0, 7) == 0);
      bus3.branch_taken_ex_i = ($urandom_range(0, 9) == 0);
      bus3.ic_hit_i          = ($urandom_range(0, 3) != 0);
      bus3.src_id_i          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus3.src_used_id_i     = 2'($urandom);
      bus3.dst_ex_i          = 5'($urandom_range(0, 7));
      bus3.dst_mem_i         = 5'($urandom_range(0, 7));
      bus3.dst_wb_i          = 5'($urandom_range(0, 7));
      bus3.we_ex_i           = 1'($urandom);
      bus3.we_mem_i          = 1'($urandom);
      bus3.we_wb_i           = 1'($urandom);
      bus3.load_ex_i         = 1'($urandom);
      cycle();
    end

    // Drive the stall counter past its range.
    set_idle();
    bus3.dc_busy_i = 1'b1;
    repeat (CNT_MAX + 3) cycle();
    check("cnt_sat_d3", 32'(bus3.stall_cnt_o), 32'(CNT_MAX));
    check("cnt_sat_d1", 32'(bus1.stall_cnt_o), 32'(CNT_MAX));
    set_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
